// File: rtl/dmem_port_arbiter.sv
// Shares the RAM data port between the CPU data path and a serial loader/debug master.
// The core owns the port by default; the loader gets single-beat slots when the core is idle or after MAX_WAIT busy cycles.
module dmem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 8,
    parameter int CW       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   core_addr_i,
    input  logic [DW-1:0]   core_din_i,
    input  logic [DW/8-1:0] core_wren_i,
    input  logic            core_rd_i,
    output logic [DW-1:0]   core_dout_o,
    output logic            core_pause_o,
    input  logic            ld_req_i,
    input  logic            ld_we_i,
    input  logic [DW/8-1:0] ld_be_i,
    input  logic [AW-1:0]   ld_addr_i,
    input  logic [DW-1:0]   ld_din_i,
    output logic            ld_gnt_o,
    output logic            ld_rvalid_o,
    output logic [DW-1:0]   ld_rdata_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_din_o,
    output logic [DW/8-1:0] mem_wren_o,
    input  logic [DW-1:0]   mem_dout_i
);

    // state  | meaning
    // S_CORE | core drives the RAM port; loader request ages in wait_cnt
    // S_LOAD | loader beat on the RAM port, core frozen
    // S_LRD  | loader read data returning from RAM, core frozen, no writes
    localparam logic [1:0] S_CORE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_LRD  = 2'd2;

    localparam int              BW      = DW / 8;
    localparam logic [CW-1:0]   WAIT_TC = CW'(MAX_WAIT);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_nxt;
    logic          core_busy;

    assign core_busy = core_rd_i | (|core_wren_i);

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            S_CORE: begin
                if (!ld_req_i) begin
                    wait_nxt = '0;
                end else if (!core_busy || (wait_cnt == WAIT_TC)) begin
                    state_nxt = S_LOAD;
                    wait_nxt  = '0;
                end else if (wait_cnt != WAIT_TC) begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            S_LOAD:  state_nxt = ld_we_i ? S_CORE : S_LRD;
            S_LRD:   state_nxt = S_CORE;
            default: state_nxt = S_CORE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_CORE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Outputs decode straight from state so reset clears them without a clock edge.
    always_comb begin
        mem_addr_o   = core_addr_i;
        mem_din_o    = core_din_i;
        mem_wren_o   = core_wren_i & {BW{rst}};
        ld_gnt_o     = 1'b0;
        ld_rvalid_o  = 1'b0;
        core_pause_o = 1'b0;
        case (state)
            S_LOAD: begin
                mem_addr_o   = ld_addr_i;
                mem_din_o    = ld_din_i;
                mem_wren_o   = ld_we_i ? ld_be_i : '0;
                ld_gnt_o     = 1'b1;
                core_pause_o = 1'b1;
            end
            S_LRD: begin
                mem_wren_o   = '0;
                ld_rvalid_o  = 1'b1;
                core_pause_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign core_dout_o = mem_dout_i;
    assign ld_rdata_o  = mem_dout_i;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: behavioural synchronous RAM, a table of idle-core loader
// transactions, and hand-written sequences for starvation, collisions and async reset.
module tb_dmem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_din = '0;
    logic [BW-1:0] core_wren = '0;
    logic          core_rd = 1'b0;
    logic [DW-1:0] core_dout;
    logic          core_pause;
    logic          ld_req = 1'b0;
    logic          ld_we = 1'b0;
    logic [BW-1:0] ld_be = '0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_din = '0;
    logic          ld_gnt;
    logic          ld_rvalid;
    logic [DW-1:0] ld_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [BW-1:0] mem_wren;
    logic [DW-1:0] mem_dout;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(8), .CW(4)) dut (
        .clk(clk), .rst(rst),
        .core_addr_i(core_addr), .core_din_i(core_din), .core_wren_i(core_wren),
        .core_rd_i(core_rd), .core_dout_o(core_dout), .core_pause_o(core_pause),
        .ld_req_i(ld_req), .ld_we_i(ld_we), .ld_be_i(ld_be), .ld_addr_i(ld_addr),
        .ld_din_i(ld_din), .ld_gnt_o(ld_gnt), .ld_rvalid_o(ld_rvalid), .ld_rdata_o(ld_rdata),
        .mem_addr_o(mem_addr), .mem_din_o(mem_din), .mem_wren_o(mem_wren),
        .mem_dout_i(mem_dout)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with 1-cycle read latency; cleared and preloaded while reset is low.
    logic [DW-1:0] ram [0:1023];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 1024; i++) ram[i] <= '0;
            ram[32'h104 >> 2] <= 32'h1234_5678;
        end else begin
            for (int b = 0; b < BW; b++)
                if (mem_wren[b]) ram[mem_addr[11:2]][8*b +: 8] <= mem_din[8*b +: 8];
        end
        mem_dout <= ram[mem_addr[11:2]];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic to_drive;
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample;
        #4;
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  be;
        logic [31:0] exp_rd;
    } ld_vec_t;

    ld_vec_t vecs [7];

    int          gnt_cyc [$];
    int          n_gnt;
    bit          pause_ok;
    logic [31:0] wr_addr [3];
    logic [31:0] wr_data [3];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'h0};
        vecs[1] = '{1'b0, 32'h104, 32'h0,         4'h0, 32'h1234_5678};
        vecs[2] = '{1'b0, 32'h100, 32'h0,         4'h0, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 32'h108, 32'hCAFE_F00D, 4'h3, 32'h0};
        vecs[4] = '{1'b0, 32'h108, 32'h0,         4'h0, 32'h0000_F00D};
        vecs[5] = '{1'b1, 32'h10C, 32'h1122_3344, 4'h0, 32'h0};
        vecs[6] = '{1'b0, 32'h10C, 32'h0,         4'h0, 32'h0};
        wr_addr = '{32'h180, 32'h184, 32'h188};
        wr_data = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};

        // Reset state
        #2;
        check("rst_gnt", ld_gnt, 0);
        check("rst_rvalid", ld_rvalid, 0);
        check("rst_pause", core_pause, 0);
        check("rst_wren", mem_wren, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;

        // Loader transactions with the core idle: grant in N+1, read data in N+2
        for (int i = 0; i < 7; i++) begin
            to_drive;
            ld_req = 1'b1; ld_we = vecs[i].we; ld_addr = vecs[i].addr;
            ld_din = vecs[i].din; ld_be = vecs[i].be;
            to_sample;
            check($sformatf("v%0d_c0_gnt", i), ld_gnt, 0);
            check($sformatf("v%0d_c0_pause", i), core_pause, 0);
            to_drive;
            to_sample;
            check($sformatf("v%0d_c1_gnt", i), ld_gnt, 1);
            check($sformatf("v%0d_c1_pause", i), core_pause, 1);
            check($sformatf("v%0d_c1_addr", i), mem_addr, vecs[i].addr);
            check($sformatf("v%0d_c1_wren", i), mem_wren, vecs[i].we ? vecs[i].be : 4'h0);
            to_drive;
            ld_req = 1'b0;
            to_sample;
            check($sformatf("v%0d_c2_gnt", i), ld_gnt, 0);
            if (vecs[i].we) begin
                check($sformatf("v%0d_c2_pause", i), core_pause, 0);
                check($sformatf("v%0d_c2_rvalid", i), ld_rvalid, 0);
            end else begin
                check($sformatf("v%0d_c2_rvalid", i), ld_rvalid, 1);
                check($sformatf("v%0d_c2_pause", i), core_pause, 1);
                check($sformatf("v%0d_c2_rdata", i), ld_rdata, vecs[i].exp_rd);
                to_drive;
                to_sample;
                check($sformatf("v%0d_c3_rvalid", i), ld_rvalid, 0);
                check($sformatf("v%0d_c3_pause", i), core_pause, 0);
            end
        end

        // Core write collides with a loader write in S_LOAD; core re-presents afterwards
        to_drive;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h300; ld_din = 32'h0000_0055; ld_be = 4'hF;
        to_drive;
        core_addr = 32'h200; core_din = 32'h0000_00AA; core_wren = 4'h1;
        to_sample;
        check("col_load_addr", mem_addr, 32'h300);
        check("col_load_wren", mem_wren, 4'hF);
        check("col_load_din", mem_din, 32'h55);
        check("col_load_pause", core_pause, 1);
        to_drive;
        ld_req = 1'b0;
        to_sample;
        check("col_core_addr", mem_addr, 32'h200);
        check("col_core_wren", mem_wren, 4'h1);
        check("col_core_pause", core_pause, 0);
        to_drive;
        core_wren = 4'h0;
        to_sample;
        check("col_ram_300", ram[32'h300 >> 2], 32'h0000_0055);
        check("col_ram_200", ram[32'h200 >> 2], 32'h0000_00AA);

        // Request dropped before grant while core busy; core read data path
        to_drive;
        core_rd = 1'b1; core_addr = 32'h104;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h100;
        to_sample;
        check("drop_c0_gnt", ld_gnt, 0);
        to_drive;
        to_sample;
        check("core_dout", core_dout, 32'h1234_5678);
        check("drop_wc1", dut.wait_cnt, 1);
        to_drive;
        to_sample;
        check("drop_wc2", dut.wait_cnt, 2);
        to_drive;
        ld_req = 1'b0;
        to_sample;
        check("drop_wc3", dut.wait_cnt, 3);
        to_drive;
        core_rd = 1'b0;
        to_sample;
        check("drop_wc_clr", dut.wait_cnt, 0);
        check("drop_nogrant", ld_gnt, 0);
        to_drive;
        to_sample;
        check("drop_nogrant2", ld_gnt, 0);

        // Core continuously busy: 3 loader writes, forced grants.
        // First grant after MAX_WAIT+1 cycles; each slot then costs 1 grant cycle + 9 aging cycles.
        n_gnt = 0;
        pause_ok = 1'b1;
        gnt_cyc.delete();
        for (int c = 0; c < 40; c++) begin
            to_drive;
            if (c == 0) begin
                core_rd = 1'b1; core_addr = 32'h40;
                ld_req = 1'b1; ld_we = 1'b1; ld_be = 4'hF;
                ld_addr = wr_addr[0]; ld_din = wr_data[0];
            end else if (gnt_cyc.size() > n_gnt) begin
                n_gnt = gnt_cyc.size();
                if (n_gnt < 3) begin
                    ld_addr = wr_addr[n_gnt]; ld_din = wr_data[n_gnt];
                end else begin
                    ld_req = 1'b0;
                end
            end
            to_sample;
            if (ld_gnt === 1'b1) gnt_cyc.push_back(c);
            if (core_pause !== ld_gnt) pause_ok = 1'b0;
            if (c == 8) check("busy_wc8", dut.wait_cnt, 8);
        end
        core_rd = 1'b0;
        check("busy_ngrants", gnt_cyc.size(), 3);
        check("busy_gnt0", (gnt_cyc.size() > 0) ? gnt_cyc[0] : -1, 9);
        check("busy_gnt1", (gnt_cyc.size() > 1) ? gnt_cyc[1] : -1, 19);
        check("busy_gnt2", (gnt_cyc.size() > 2) ? gnt_cyc[2] : -1, 29);
        check("busy_pause_eq_gnt", pause_ok, 1);
        for (int k = 0; k < 3; k++)
            check($sformatf("busy_ram%0d", k), ram[wr_addr[k][11:2]], wr_data[k]);

        // Async reset during S_LRD
        to_drive;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h104;
        to_drive;
        to_drive;
        ld_req = 1'b0;
        core_addr = 32'h200; core_din = 32'h77; core_wren = 4'hF;
        to_sample;
        check("lrd_rvalid", ld_rvalid, 1);
        check("lrd_wren_forced0", mem_wren, 0);
        check("lrd_addr_core", mem_addr, 32'h200);
        check("lrd_pause", core_pause, 1);
        #1;
        rst = 1'b0;
        #1;
        check("arst_rvalid", ld_rvalid, 0);
        check("arst_pause", core_pause, 0);
        check("arst_wren", mem_wren, 0);
        core_wren = 4'h0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        to_drive;
        to_sample;
        check("arst_state", dut.state, 0);
        check("arst_wc", dut.wait_cnt, 0);
        check("arst_rvalid_lost", ld_rvalid, 0);
        check("arst_gnt", ld_gnt, 0);
        to_drive;
        to_sample;
        check("arst_rvalid_lost2", ld_rvalid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
